mole_display_driver: RTL and testbench
======================================

# mole_display_driver

Display back-end for the whack-a-mole game. Consumes the game FSM's `state`, `score`, `lives` and `mole` outputs and drives a 4-digit multiplexed active-low seven-segment display, the mole LED and a game-over LED. It sits between the game core and board pins and owns all refresh, blink and event-flash timing, so the game core stays free of display timers.

## Interface
Parameters:
- `REFRESH_DIV`, default 100_000. Clock cycles each digit is held.
- `BLINK_DIV`, default 50_000_000. Clock cycles per END_SCREEN blink half-period.
- `FLASH_CYCLES`, default 25_000_000. Event-flash duration in cycles.

Ports:
- `clk`, input, 1. System clock.
- `reset`, input, 1. Asynchronous, active-high.
- `state_in`, input, 3. Game state: 000 IDLE, 001 GAMEPLAY, 010 END_SCREEN.
- `score_in`, input, 4. Score, 0–15.
- `lives_in`, input, 4. Lives remaining.
- `mole_in`, input, 1. Mole visible.
- `seg`, output, 7. `{g,f,e,d,c,b,a}`, active-low.
- `an`, output, 4. Digit enables, active-low. `an[0]` is the rightmost digit.
- `dp`, output, 1. Decimal point, active-low.
- `mole_led`, output, 1. Mole LED.
- `game_over_led`, output, 1. High in END_SCREEN.

## Operation
- **Input capture:** inputs are captured into registers every cycle. Reset values are state=IDLE, score=0, lives=3, mole=0.
- **Refresh counter:** counts 0..REFRESH_DIV-1. At terminal count it wraps and the 2-bit digit index increments. Index wraps 3→0.
- **Digit content by captured state:**
  - IDLE: dash (`7'b0111111`) on all digits.
  - GAMEPLAY:
    - d0 = score ones.
    - d1 = score tens, blanked when score < 10 (leading-zero suppression).
    - d2 = blank.
    - d3 = lives (0–9 decimal, ≥10 shows dash).
  - END_SCREEN: as GAMEPLAY, except d3 = 'E' (`7'b0000110`).
  - Codes 011–111: all blank. `mole_led`=0, `game_over_led`=0.
- **Score split:** tens = (score ≥ 10), ones = score − 10·tens. Computed in 4 bits; no wider arithmetic.
- **Blink:**
  - Blink counter and phase are active only in END_SCREEN. Phase toggles when the counter reaches BLINK_DIV-1.
  - On entering or leaving END_SCREEN: counter clears and phase is set to 1 (visible).
  - Phase 0: `an`=4'hF, `seg`=7'h7F.
- **mole_led:**
  - GAMEPLAY: captured mole.
  - END_SCREEN: blink phase.
  - Otherwise: 0.
- `game_over_led` = (captured state == END_SCREEN).
- A state change does not reset the refresh counter or digit index.

## Timing
- Reset values:
  - `seg`=7'h7F, `an`=4'hF, `dp`=1, `mole_led`=0, `game_over_led`=0.
  - Counters 0, digit index 0, blink phase 1, flash timer 0.
- All outputs are registered. Latency from an input change to the corresponding output is 2 cycles (capture, then output), for the currently selected digit.
- First clock edge after reset release: `an`=4'b1110, `seg`=dash.
- Reset asserted mid-blink or mid-flash: all timers clear immediately (asynchronous). No residual blink or flash after release.

## Configuration
- `DISP_EVENT_FLASH_EN` defined:
  - An event is (captured score increments) or (captured lives decrements), detected while the previous captured state is GAMEPLAY.
  - An event loads the flash timer with FLASH_CYCLES. `dp`=0 on every active digit while the timer is nonzero.
  - A new event during a flash reloads the timer to FLASH_CYCLES.
  - Simultaneous score and lives events count as one reload.
  - Flash is suppressed in blink phase 0.
- Not defined: no flash timer logic; `dp` is constant 1.

## Structure
- Package `disp_pkg` holds:
  - State codes IDLE/GAMEPLAY/END_SCREEN.
  - Glyph constants: digits 0–9, DASH, E, BLANK.
  - Glyph select enum.
- Sub-module `seven_seg_encoder`: combinational glyph select → `seg[6:0]` pattern. Only one instance, on the output-register input.

## Test plan
Benches use REFRESH_DIV=4, BLINK_DIV=8, FLASH_CYCLES=10.
- **Reset/IDLE:** hold reset → `seg`=7'h7F, `an`=4'hF, `dp`=1, LEDs 0. Release → `an` steps 1110,1101,1011,0111 every 4 cycles, `seg`=7'b0111111 throughout.
- **Two-digit score:** GAMEPLAY, score=12, lives=3 → per slot:
  - `an`=1110 `seg`=7'b0100100
  - `an`=1101 `seg`=7'b1111001
  - `an`=1011 `seg`=7'h7F
  - `an`=0111 `seg`=7'b0110000
- **Single-digit score:** score=7 → d1 blank (7'h7F), d0=7'b1111000. `mole_in` 0→1 → `mole_led` high exactly 2 cycles later.
- **END_SCREEN blink:**
  - `state_in`=010 → `game_over_led`=1, d3=7'b0000110.
  - `mole_led` and display visibility toggle every 8 cycles.
  - Return to IDLE mid-off-phase → visible dashes within 2 cycles, `mole_led`=0.
- **Event flash (macro on):** score 3→4 → `dp`=0 for 10 cycles. Lives decrement at cycle 5 → `dp` stays 0 for 10 more cycles.
- **Event flash (macro off):** same stimulus → `dp`=1 throughout.
- **Reset mid-operation:** assert reset during END_SCREEN blink phase 0 → all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/disp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | disp_pkg: state codes, glyph patterns and glyph select for the   |
// | whack-a-mole display driver.                  Revision: 1.0      |
// +------------------------------------------------------------------+
package disp_pkg;

  localparam logic [2:0] ST_IDLE     = 3'b000;
  localparam logic [2:0] ST_GAMEPLAY = 3'b001;
  localparam logic [2:0] ST_END      = 3'b010;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [3:0] {
    GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4,
    GLYPH_5, GLYPH_6, GLYPH_7, GLYPH_8, GLYPH_9,
    GLYPH_DASH, GLYPH_E, GLYPH_BLANK
  } glyph_e;

  // Decimal digit glyph; values above 9 show a dash.
  function automatic glyph_e digit_glyph(input logic [3:0] value);
    return (value <= 4'd9) ? glyph_e'(value) : GLYPH_DASH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_encoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seven_seg_encoder: glyph select to active-low segment pattern.   |
// |                                               Revision: 1.0      |
// +------------------------------------------------------------------+
module seven_seg_encoder
  import disp_pkg::*;
(
  input  logic [3:0] glyph,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (glyph)
      GLYPH_0:    seg = SEG_0;
      GLYPH_1:    seg = SEG_1;
      GLYPH_2:    seg = SEG_2;
      GLYPH_3:    seg = SEG_3;
      GLYPH_4:    seg = SEG_4;
      GLYPH_5:    seg = SEG_5;
      GLYPH_6:    seg = SEG_6;
      GLYPH_7:    seg = SEG_7;
      GLYPH_8:    seg = SEG_8;
      GLYPH_9:    seg = SEG_9;
      GLYPH_DASH: seg = SEG_DASH;
      GLYPH_E:    seg = SEG_E;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mole_display_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mole_display_driver: 4-digit muxed 7-seg, mole and game-over LED |
// | back-end. Optional event flash: DISP_EVENT_FLASH_EN. Rev: 1.0    |
// +------------------------------------------------------------------+
module mole_display_driver
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLINK_DIV    = 50_000_000,
  parameter int FLASH_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state_in,
  input  logic [3:0] score_in,
  input  logic [3:0] lives_in,
  input  logic       mole_in,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       mole_led,
  output logic       game_over_led
);

  localparam int REFRESH_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [2:0]           state_q;
  logic [3:0]           score_q;
  logic [3:0]           lives_q;
  logic                 mole_q;
  logic [REFRESH_W-1:0] refresh_cnt;
  logic [1:0]           digit_idx;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 blink_phase;
  logic                 in_end;
  logic                 visible;
  logic                 score_tens;
  logic [3:0]           score_ones;
  glyph_e               glyph;
  logic [6:0]           seg_glyph;
  logic                 mole_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      score_q <= 4'd0;
      lives_q <= 4'd3;
      mole_q  <= 1'b0;
    end else begin
      state_q <= state_in;
      score_q <= score_in;
      lives_q <= lives_in;
      mole_q  <= mole_in;
    end
  end

  // Digit scan runs freely; game state changes never disturb it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
    end else if (refresh_cnt == REFRESH_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + REFRESH_W'(1);
    end
  end

  assign in_end = (state_q == ST_END);

  // Outside END_SCREEN the blink is held cleared and visible, so both
  // entering and leaving restart it from the visible phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!in_end) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  assign visible    = !(in_end && !blink_phase);
  assign score_tens = (score_q >= 4'd10);
  assign score_ones = score_q - (score_tens ? 4'd10 : 4'd0);

  always_comb begin
    glyph = GLYPH_BLANK;
    if (state_q == ST_IDLE) begin
      glyph = GLYPH_DASH;
    end else if (state_q == ST_GAMEPLAY || in_end) begin
      case (digit_idx)
        2'd0:    glyph = digit_glyph(score_ones);
        2'd1:    glyph = score_tens ? GLYPH_1 : GLYPH_BLANK;
        2'd2:    glyph = GLYPH_BLANK;
        default: glyph = in_end ? GLYPH_E : digit_glyph(lives_q);
      endcase
    end
  end

  seven_seg_encoder u_encoder (
    .glyph (glyph),
    .seg   (seg_glyph)
  );

  always_comb begin
    mole_next = 1'b0;
    if (state_q == ST_GAMEPLAY) mole_next = mole_q;
    else if (in_end)            mole_next = blink_phase;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg           <= SEG_BLANK;
      an            <= 4'hF;
      mole_led      <= 1'b0;
      game_over_led <= 1'b0;
    end else begin
      seg           <= visible ? seg_glyph : SEG_BLANK;
      an            <= visible ? ~(4'b0001 << digit_idx) : 4'hF;
      mole_led      <= mole_next;
      game_over_led <= in_end;
    end
  end

`ifdef DISP_EVENT_FLASH_EN
  localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);

  logic [2:0]         state_prev;
  logic [3:0]         score_prev;
  logic [3:0]         lives_prev;
  logic [FLASH_W-1:0] flash_timer;
  logic [FLASH_W-1:0] flash_next;
  logic               flash_event;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_prev <= ST_IDLE;
      score_prev <= 4'd0;
      lives_prev <= 4'd3;
    end else begin
      state_prev <= state_q;
      score_prev <= score_q;
      lives_prev <= lives_q;
    end
  end

  assign flash_event = (state_prev == ST_GAMEPLAY) &&
                       ((score_q > score_prev) || (lives_q < lives_prev));

  always_comb begin
    flash_next = flash_timer;
    if (flash_event)              flash_next = FLASH_W'(FLASH_CYCLES);
    else if (flash_timer != '0)   flash_next = flash_timer - FLASH_W'(1);
  end

  // dp tracks the timer's next value so it lights on the load cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_timer <= '0;
      dp          <= 1'b1;
    end else begin
      flash_timer <= flash_next;
      dp          <= !(visible && (flash_next != '0));
    end
  end
`else
  assign dp = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mole_display_driver.sv
`default_nettype none
// Bench for mole_display_driver: table vectors, hand sequences for blink,
// flash and reset, plus random traffic checked against a history model.
module tb_mole_display_driver;

  localparam int REFRESH_DIV  = 4;
  localparam int BLINK_DIV    = 8;
  localparam int FLASH_CYCLES = 10;
`ifdef DISP_EVENT_FLASH_EN
  localparam bit FLASH_ON = 1'b1;
`else
  localparam bit FLASH_ON = 1'b0;
`endif

  localparam logic [2:0] S_IDLE = 3'd0, S_GP = 3'd1, S_END = 3'd2;
  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000, D5 = 7'b0010010, D7 = 7'b1111000;
  localparam logic [6:0] D9 = 7'b0010000, DASH = 7'b0111111;
  localparam logic [6:0] EGL = 7'b0000110, BLANK = 7'h7F;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] state_in = 3'd0;
  logic [3:0] score_in = 4'd0;
  logic [3:0] lives_in = 4'd3;
  logic       mole_in = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp, mole_led, game_over_led;

  mole_display_driver #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLINK_DIV    (BLINK_DIV),
    .FLASH_CYCLES (FLASH_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .state_in      (state_in),
    .score_in      (score_in),
    .lives_in      (lives_in),
    .mole_in       (mole_in),
    .seg           (seg),
    .an            (an),
    .dp            (dp),
    .mole_led      (mole_led),
    .game_over_led (game_over_led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_seg"}, 32'(seg), 32'(BLANK));
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_dp"}, 32'(dp), 32'd1);
    chk({tag, "_mole"}, 32'(mole_led), 32'd0);
    chk({tag, "_go"}, 32'(game_over_led), 32'd0);
  endtask

  // ---------------- reference model over the captured-input history
  typedef struct {
    logic [2:0] st;
    logic [3:0] score;
    logic [3:0] lives;
    logic       mole;
  } cap_t;

  cap_t       hist[$];
  cap_t       rst_cap, m_c1, m_c2, m_now;
  bit         model_on = 1'b0;
  int         n = 0;
  int         last_ev = -1000;
  int         m_run, m_d;
  logic       m_phase, m_vis, e_dp, e_mole, e_go;
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic [6:0] dig [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000};

  function automatic logic [6:0] ref_seg(input cap_t c, input int d);
    if (c.st == S_IDLE) return DASH;
    if (c.st != S_GP && c.st != S_END) return BLANK;
    case (d)
      0: return dig[int'(c.score) % 10];
      1: return (c.score >= 10) ? dig[1] : BLANK;
      2: return BLANK;
      default: begin
        if (c.st == S_END) return EGL;
        return (c.lives <= 9) ? dig[int'(c.lives)] : DASH;
      end
    endcase
  endfunction

  always @(posedge clk) begin
    if (model_on) begin
      #1;
      n++;
      m_c1 = hist[$];
      m_c2 = hist[$-1];
      m_run = 0;
      for (int i = hist.size() - 2; i >= 0 && hist[i].st == S_END; i--) m_run++;
      m_phase = ((m_run / BLINK_DIV) % 2) == 0;
      m_vis   = !(m_c1.st == S_END && !m_phase);
      m_d     = ((n - 1) / REFRESH_DIV) % 4;
      if (m_c2.st == S_GP && (m_c1.score > m_c2.score || m_c1.lives < m_c2.lives))
        last_ev = n;
      e_seg  = m_vis ? ref_seg(m_c1, m_d) : BLANK;
      e_an   = m_vis ? ~(4'b0001 << m_d) : 4'hF;
      e_dp   = !(FLASH_ON && m_vis && (n - last_ev) < FLASH_CYCLES);
      e_mole = (m_c1.st == S_GP) ? m_c1.mole : (m_c1.st == S_END) ? m_phase : 1'b0;
      e_go   = (m_c1.st == S_END);
      checks++;
      if (seg !== e_seg || an !== e_an || dp !== e_dp || mole_led !== e_mole ||
          game_over_led !== e_go) begin
        errors++;
        $display("FAIL model cyc=%0d: got seg=%b an=%b dp=%b mole=%b go=%b expected seg=%b an=%b dp=%b mole=%b go=%b",
                 n, seg, an, dp, mole_led, game_over_led, e_seg, e_an, e_dp, e_mole, e_go);
      end
      m_now.st = state_in; m_now.score = score_in; m_now.lives = lives_in; m_now.mole = mole_in;
      hist.push_back(m_now);
    end
  end

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
    hist.push_back(rst_cap);
    hist.push_back(rst_cap);
    n = 0;
    last_ev = -1000;
    model_on = 1'b1;
  endtask

  task automatic wait_blank(input string name);
    int cnt = 0;
    while (an != 4'hF && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk(name, 32'(an == 4'hF), 32'd1);
  endtask

  function automatic int an_to_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // ---------------- table vectors: expected digits packed {d3,d2,d1,d0}
  typedef struct {
    logic [2:0]      st;
    logic [3:0]      score;
    logic [3:0]      lives;
    logic [3:0][6:0] exp;
  } vec_t;

  localparam int NV = 8;
  vec_t       vecs[NV];
  logic [3:0] an_seq[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    int idx, cnt, len;
    int r, hold;

    rst_cap.st = S_IDLE; rst_cap.score = 4'd0; rst_cap.lives = 4'd3; rst_cap.mole = 1'b0;
    vecs[0] = '{S_IDLE, 4'd5,  4'd2,  {DASH, DASH, DASH, DASH}};
    vecs[1] = '{S_GP,   4'd12, 4'd3,  {D3, BLANK, D1, D2}};
    vecs[2] = '{S_GP,   4'd7,  4'd9,  {D9, BLANK, BLANK, D7}};
    vecs[3] = '{S_GP,   4'd15, 4'd12, {DASH, BLANK, D1, D5}};
    vecs[4] = '{S_GP,   4'd0,  4'd0,  {D0, BLANK, BLANK, D0}};
    vecs[5] = '{3'b101, 4'd9,  4'd9,  {BLANK, BLANK, BLANK, BLANK}};
    vecs[6] = '{S_END,  4'd10, 4'd1,  {EGL, BLANK, D1, D0}};
    vecs[7] = '{3'b011, 4'd3,  4'd3,  {BLANK, BLANK, BLANK, BLANK}};

    // Reset and IDLE scan
    repeat (3) @(negedge clk);
    chk_reset_vals("reset_hold");
    release_reset();
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      chk($sformatf("scan_an%0d", k), 32'(an), 32'(an_seq[k / 4]));
      chk($sformatf("scan_seg%0d", k), 32'(seg), 32'(DASH));
    end

    // Table-driven digit content
    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      state_in = vecs[v].st; score_in = vecs[v].score; lives_in = vecs[v].lives;
      repeat (12) @(posedge clk);
      for (int k = 0; k < 16; k++) begin
        @(posedge clk); #1;
        idx = an_to_idx(an);
        chk($sformatf("vec%0d_an_valid", v), 32'(idx >= 0 || (an == 4'hF && vecs[v].st == S_END)), 32'd1);
        if (idx >= 0) chk($sformatf("vec%0d_d%0d", v, idx), 32'(seg), 32'(vecs[v].exp[idx]));
      end
    end

    // Mole LED latency
    @(negedge clk);
    state_in = S_GP; score_in = 4'd7; lives_in = 4'd3; mole_in = 1'b0;
    repeat (6) @(negedge clk);
    mole_in = 1'b1;
    @(posedge clk); #1; chk("mole_lat1", 32'(mole_led), 32'd0);
    @(posedge clk); #1; chk("mole_lat2", 32'(mole_led), 32'd1);

    // END_SCREEN blink and exit mid-off
    @(negedge clk);
    state_in = S_END; mole_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; chk("go_led", 32'(game_over_led), 32'd1);
    wait_blank("blink_off_reached");
    len = 0;
    while (an == 4'hF && len < 40) begin len++; @(posedge clk); #1; end
    chk("blink_off_len", 32'(len), 32'd8);
    len = 0;
    while (an != 4'hF && len < 40) begin len++; @(posedge clk); #1; end
    chk("blink_on_len", 32'(len), 32'd8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    state_in = S_IDLE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("exit_visible", 32'(an != 4'hF), 32'd1);
    chk("exit_seg", 32'(seg), 32'(DASH));
    chk("exit_mole", 32'(mole_led), 32'd0);
    chk("exit_go", 32'(game_over_led), 32'd0);

    // Event flash: single score event, then score event plus later lives event
    @(negedge clk);
    state_in = S_GP; score_in = 4'd3; lives_in = 4'd3;
    repeat (25) @(negedge clk);
    score_in = 4'd4;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin @(posedge clk); #1; if (dp == 1'b0) cnt++; end
    chk("flash_single", 32'(cnt), FLASH_ON ? 32'd10 : 32'd0);
    @(negedge clk);
    score_in = 4'd5;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (dp == 1'b0) cnt++;
      if (k == 4) begin @(negedge clk); lives_in = 4'd2; end
    end
    chk("flash_reload", 32'(cnt), FLASH_ON ? 32'd15 : 32'd0);

    // Random traffic against the model
    for (int s = 0; s < 250; s++) begin
      @(negedge clk);
      r = $urandom_range(0, 9);
      state_in = (r < 3) ? S_IDLE : (r < 6) ? S_GP : (r < 9) ? S_END : 3'($urandom_range(3, 7));
      if ($urandom_range(0, 3) == 0) score_in = 4'($urandom);
      if ($urandom_range(0, 3) == 0) lives_in = 4'($urandom);
      hold = $urandom_range(1, 25);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) score_in = score_in + 4'd1;
        if ($urandom_range(0, 7) == 0) lives_in = lives_in - 4'd1;
        mole_in = 1'($urandom);
      end
    end

    // Asynchronous reset during blink-off
    @(negedge clk);
    state_in = S_END; score_in = 4'd9; lives_in = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    wait_blank("rst_off_reached");
    @(negedge clk);
    #2;
    model_on = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    repeat (3) @(negedge clk);
    release_reset();
    repeat (40) @(posedge clk);
    #2;

    model_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
